// File: rtl/serial_adder.sv
// Bit-serial adder: (cout,sum) = a + b + cin, one bit per clock, LSB first.
// The per-bit full adder is nine sheffer (NAND) cells; carry lives in a flop between bits.

module sheffer (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $error("serial_adder: WIDTH must be in 2..64");
    end

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Full adder from nine NANDs: n1..n4 form a^b, n5..n8 form the sum, n9 the carry.
    logic fa_a, fa_b, fa_c;
    logic n1, n2, n3, x1, n5, n6, n7, fa_s, fa_co;

    assign fa_a = a_sh_q[0];
    assign fa_b = b_sh_q[0];
    assign fa_c = carry_q;

    sheffer u_n1 (.a(fa_a), .b(fa_b), .y(n1));
    sheffer u_n2 (.a(fa_a), .b(n1),   .y(n2));
    sheffer u_n3 (.a(fa_b), .b(n1),   .y(n3));
    sheffer u_n4 (.a(n2),   .b(n3),   .y(x1));
    sheffer u_n5 (.a(x1),   .b(fa_c), .y(n5));
    sheffer u_n6 (.a(x1),   .b(n5),   .y(n6));
    sheffer u_n7 (.a(fa_c), .b(n5),   .y(n7));
    sheffer u_n8 (.a(n6),   .b(n7),   .y(fa_s));
    sheffer u_n9 (.a(n1),   .b(n5),   .y(fa_co));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            RUN: begin
                acc_d   = {fa_s, acc_q[WIDTH-1:1]};
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {fa_s, acc_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new operation; DONE otherwise falls back to IDLE.
                busy_d  = 1'b0;
                state_d = IDLE;
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial binary adder: adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
- The per-bit full adder is structural, built from the existing sheffer (NAND) cell: 9 instances, no behavioural `+`.
- Carry is held in a flop between bits; a start/busy/done handshake frames each operation.
- Sequential successor to the combinational NAND/adder cells; sits under wider arithmetic blocks that trade latency for area.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..64; a width outside that range is an elaboration error.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- cin  in  1  carry-in; captured on accepted start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse: sum/cout valid and just updated.
- sum  out  WIDTH  registered result; (cout,sum) = a + b + cin.
- cout  out  1  registered carry-out of bit WIDTH-1.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Bit counter, carry flop, operand and shift registers all cleared.
  - Reset mid-operation aborts it: no done pulse, sum/cout read 0.
- States: IDLE, RUN, DONE; counter width is $clog2(WIDTH).
- IDLE:
  - start=1 at edge k: latch a/b/cin, counter=0, go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - At each edge, the full adder combines a_reg[0], b_reg[0] and carry.
  - The sum bit shifts in at the MSB of the internal shift register; a_reg/b_reg shift right; the carry flop takes the carry out; counter increments.
  - On the edge that processes bit WIDTH-1 (edge k+WIDTH), copy the shift register into sum and the final carry into cout, then go to DONE.
- DONE (busy=0, done=1) lasts exactly one cycle:
  - start=1 in this cycle is accepted like IDLE (back-to-back operation); otherwise go to IDLE.
- Latency:
  - busy is high for exactly WIDTH cycles after the accepting edge.
  - done is high in the cycle after edge k+WIDTH.
  - Throughput with back-to-back starts is one result per WIDTH+1 cycles.
- Output stability:
  - sum/cout change only on the DONE-entry edge (or reset).
  - They hold the previous result throughout a new RUN.
- start while busy=1: ignored entirely; no queuing, and operand changes on a/b/cin have no effect.
- Wrap-around: the result is mod 2^WIDTH, with overflow reported only in cout. All-ones + all-ones + 1 gives sum = all-ones, cout=1.
- No combinational path from inputs to any output; all outputs come straight from flops.

Test Plan:
- Reset, WIDTH=8: hold rst_n=0 for 3 cycles with start=1 and random a/b -> busy=0, done=0, sum=8'h00, cout=0; no done pulse after release until the next start.
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, 1-cycle start -> busy high exactly 8 cycles, done pulses on cycle 9 after the start edge, sum=8'h10, cout=0. Then a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Busy ignore: start a=8'h12, b=8'h34; at cycle 3 pulse start with a=8'hAA, b=8'h55 -> single done, sum=8'h46, cout=0. sum keeps the prior value until that done.
- Back-to-back: assert start in the DONE cycle with a=8'h80, b=8'h80 -> next done exactly 9 cycles later, sum=8'h00, cout=1; the first result remains visible meanwhile.
- Reset mid-operation: deassert rst_n asynchronously (off-edge) 4 cycles into RUN -> busy/done/sum/cout drop to 0 immediately. After release, a=8'h01, b=8'h01 -> sum=8'h02.
- WIDTH=4 exhaustive: all 512 (a,b,cin) combinations -> {cout,sum} === a+b+cin, with the done-to-start spacing checked every time.
